// File: rtl/tdm_pkg.sv
// Shared definitions for the 8:1 TDM select path.
// Both the mux-side slot generator and this demux use these lane and slot-width defaults.
package tdm_pkg;

  localparam int TDM_LANES = 8;
  localparam int TDM_SEL_W = $clog2(TDM_LANES);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } tdm_state_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-LANES slot counter. load0 takes priority over inc and forces the next value to 1.
// Latency: 1 cycle from inc/load0 to cnt. It never stalls, and it holds its value when idle.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int LANES = TDM_LANES,
  parameter int SEL_W = TDM_SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             load0,
  output logic [SEL_W-1:0] cnt,
  output logic             wrap
);

  logic [SEL_W-1:0] cnt_q;
  logic [SEL_W-1:0] cnt_d;

  assign wrap = (cnt_q == SEL_W'(LANES - 1));
  assign cnt  = cnt_q;

  // load0 means the current bit was slot 0, so the next bit goes to slot 1.
  always_comb begin
    cnt_d = cnt_q;
    if (load0) begin
      cnt_d = SEL_W'(1);
    end else if (inc) begin
      cnt_d = wrap ? '0 : cnt_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM receive demux: it steers serial bits into lanes, locks on a slot-0 sync marker, and strobes each full frame.
// All outputs are registered with 1-cycle latency. There is no backpressure; din_valid low simply holds all state.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int LANES = TDM_LANES,
  parameter int SEL_W = TDM_SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [LANES-1:0] y,
  output logic [LANES-1:0] frame,
  output logic             frame_valid,
  output logic [SEL_W-1:0] slot,
  output logic             locked,
  output logic             sync_err
);

  tdm_state_t       state_q, state_d;
  logic [LANES-1:0] y_q, y_d;
  logic [LANES-2:0] shadow_q, shadow_d;
  logic [LANES-1:0] frame_q, frame_d;
  logic             fv_q, fv_d;
  logic             err_q, err_d;

  logic             inc, load0, wrap;
  logic             wr_en, early_sync, frame_done;
  logic [SEL_W-1:0] slot_cnt;
  logic [SEL_W-1:0] wr_idx;

  tdm_slot_counter #(
    .LANES (LANES),
    .SEL_W (SEL_W)
  ) u_slot (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc),
    .load0 (load0),
    .cnt   (slot_cnt),
    .wrap  (wrap)
  );

  always_comb begin
    state_d    = state_q;
    inc        = 1'b0;
    load0      = 1'b0;
    wr_en      = 1'b0;
    early_sync = 1'b0;
    frame_done = 1'b0;
    fv_d       = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      HUNT: begin
        if (din_valid && frame_sync) begin
          load0   = 1'b1;
          wr_en   = 1'b1;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (din_valid) begin
          wr_en = 1'b1;
          // An early sync re-aligns and discards the partial frame. This beats end-of-frame.
          if (frame_sync && (slot_cnt != '0)) begin
            early_sync = 1'b1;
            load0      = 1'b1;
            err_d      = 1'b1;
          end else begin
            inc        = 1'b1;
            frame_done = wrap;
            fv_d       = wrap;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  assign wr_idx = ((state_q == HUNT) || early_sync) ? '0 : slot_cnt;

  // The shadow holds slots 0..LANES-2. The final bit goes straight into frame.
  always_comb begin
    y_d      = y_q;
    shadow_d = shadow_q;
    frame_d  = frame_q;
    for (int k = 0; k < LANES; k++) begin
      if (wr_en && (wr_idx == SEL_W'(k))) begin
        y_d[k] = din;
      end
    end
    for (int k = 0; k < LANES - 1; k++) begin
      if (wr_en && (wr_idx == SEL_W'(k))) begin
        shadow_d[k] = din;
      end
    end
    if (frame_done) begin
      frame_d = {din, shadow_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      y_q      <= '0;
      shadow_q <= '0;
      frame_q  <= '0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
    end
  end

  assign y           = y_q;
  assign frame       = frame_q;
  assign frame_valid = fv_q;
  assign slot        = slot_cnt;
  assign locked      = (state_q == LOCK);
  assign sync_err    = err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux: a vector table for lock, capture and misaligned sync, plus
// hand-written sequences for reset, gapped input and a continuous stream.
module tb_tdm_demux;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       frame_sync = 1'b0;
  logic [7:0] y;
  logic [7:0] frame;
  logic       frame_valid;
  logic [2:0] slot;
  logic       locked;
  logic       sync_err;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       v;
    logic       s;
    logic       d;
    logic [7:0] ey;
    logic [7:0] ef;
    logic       efv;
    logic [2:0] es;
    logic       elk;
    logic       eerr;
  } vec_t;

  vec_t tbl[$];

  tdm_demux #(.LANES(8), .SEL_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .frame_sync  (frame_sync),
    .y           (y),
    .frame       (frame),
    .frame_valid (frame_valid),
    .slot        (slot),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  task automatic add(input logic v, s, d, input logic [7:0] ey, ef,
                     input logic efv, input logic [2:0] es, input logic elk, eerr);
    vec_t t;
    t.v = v; t.s = s; t.d = d; t.ey = ey; t.ef = ef;
    t.efv = efv; t.es = es; t.elk = elk; t.eerr = eerr;
    tbl.push_back(t);
  endtask

  task automatic check(input string nm, input logic [7:0] ey, ef, input logic efv,
                       input logic [2:0] es, input logic elk, eerr);
    n_vec++;
    if (y !== ey) begin
      n_err++; $display("FAIL %s y got %h want %h", nm, y, ey);
    end
    if (frame !== ef) begin
      n_err++; $display("FAIL %s frame got %h want %h", nm, frame, ef);
    end
    if (frame_valid !== efv) begin
      n_err++; $display("FAIL %s frame_valid got %b want %b", nm, frame_valid, efv);
    end
    if (slot !== es) begin
      n_err++; $display("FAIL %s slot got %0d want %0d", nm, slot, es);
    end
    if (locked !== elk) begin
      n_err++; $display("FAIL %s locked got %b want %b", nm, locked, elk);
    end
    if (sync_err !== eerr) begin
      n_err++; $display("FAIL %s sync_err got %b want %b", nm, sync_err, eerr);
    end
  endtask

  task automatic step(input logic v, s, d);
    @(negedge clk);
    din_valid = v; frame_sync = s; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    din_valid = 1'b0; frame_sync = 1'b0; din = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] ym;
    logic [7:0] fm;
    logic [7:0] frames [4];
    int         pulses;

    // Hunt filtering, then lock and capture 8'h4D.
    for (int i = 0; i < 5; i++) add(1, 0, 1, 8'h00, 8'h00, 0, 3'd0, 0, 0);
    add(0, 1, 1, 8'h00, 8'h00, 0, 3'd0, 0, 0);
    add(1, 1, 1, 8'h01, 8'h00, 0, 3'd1, 1, 0);
    add(1, 0, 0, 8'h01, 8'h00, 0, 3'd2, 1, 0);
    add(1, 0, 1, 8'h05, 8'h00, 0, 3'd3, 1, 0);
    add(1, 0, 1, 8'h0D, 8'h00, 0, 3'd4, 1, 0);
    add(1, 0, 0, 8'h0D, 8'h00, 0, 3'd5, 1, 0);
    add(1, 0, 0, 8'h0D, 8'h00, 0, 3'd6, 1, 0);
    add(1, 0, 1, 8'h4D, 8'h00, 0, 3'd7, 1, 0);
    add(1, 0, 0, 8'h4D, 8'h4D, 1, 3'd0, 1, 0);
    add(0, 0, 0, 8'h4D, 8'h4D, 0, 3'd0, 1, 0);
    // Partial frame up to slot 3, then an early sync starts 8'hA5.
    add(1, 0, 1, 8'h4D, 8'h4D, 0, 3'd1, 1, 0);
    add(1, 0, 1, 8'h4F, 8'h4D, 0, 3'd2, 1, 0);
    add(1, 0, 1, 8'h4F, 8'h4D, 0, 3'd3, 1, 0);
    add(1, 1, 1, 8'h4F, 8'h4D, 0, 3'd1, 1, 1);
    add(1, 0, 0, 8'h4D, 8'h4D, 0, 3'd2, 1, 0);
    add(1, 0, 1, 8'h4D, 8'h4D, 0, 3'd3, 1, 0);
    add(1, 0, 0, 8'h45, 8'h4D, 0, 3'd4, 1, 0);
    add(1, 0, 0, 8'h45, 8'h4D, 0, 3'd5, 1, 0);
    add(1, 0, 1, 8'h65, 8'h4D, 0, 3'd6, 1, 0);
    add(1, 0, 0, 8'h25, 8'h4D, 0, 3'd7, 1, 0);
    add(1, 0, 1, 8'hA5, 8'hA5, 1, 3'd0, 1, 0);
    // A sync exactly at slot 0 while locked is not an error.
    add(1, 1, 0, 8'hA4, 8'hA5, 0, 3'd1, 1, 0);

    #1 rst_n = 1'b0;
    #1 check("reset", 8'h00, 8'h00, 0, 3'd0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].s, tbl[i].d);
      check($sformatf("vec%0d", i), tbl[i].ey, tbl[i].ef, tbl[i].efv, tbl[i].es,
            tbl[i].elk, tbl[i].eerr);
    end

    // Asynchronous reset in the middle of a partial frame.
    do_reset();
    step(1, 1, 1);
    step(1, 0, 1);
    step(1, 0, 1);
    check("pre_rst", 8'h07, 8'h00, 0, 3'd3, 1, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_rst", 8'h00, 8'h00, 0, 3'd0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1);
      check($sformatf("post_rst%0d", i), 8'h00, 8'h00, 0, 3'd0, 0, 0);
    end

    // Gapped input: 0-3 idle cycles between bits. The idle cycles carry a stray sync.
    do_reset();
    pat = 8'h4D; ym = 8'h00; pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, (i == 0), pat[i]);
      ym[i] = pat[i];
      if (frame_valid === 1'b1) pulses++;
      check($sformatf("gap_bit%0d", i), ym, (i == 7) ? 8'h4D : 8'h00, (i == 7),
            3'((i + 1) % 8), 1, 0);
      for (int g = 0; g < i % 4; g++) begin
        step(0, 1, 1);
        if (frame_valid === 1'b1) pulses++;
        check($sformatf("gap_idle%0d_%0d", i, g), ym, (i == 7) ? 8'h4D : 8'h00, 0,
              3'((i + 1) % 8), 1, 0);
      end
    end
    n_vec++;
    if (pulses != 1) begin
      n_err++; $display("FAIL gap_pulses got %0d want 1", pulses);
    end

    // Continuous stream: 4 back-to-back frames, with a sync only on the first bit.
    do_reset();
    frames[0] = 8'h3C; frames[1] = 8'hC3; frames[2] = 8'h01; frames[3] = 8'h80;
    ym = 8'h00; fm = 8'h00;
    for (int f = 0; f < 4; f++) begin
      for (int b = 0; b < 8; b++) begin
        pat = frames[f];
        step(1, (f == 0 && b == 0), pat[b]);
        ym[b] = pat[b];
        if (b == 7) fm = frames[f];
        check($sformatf("stream_f%0d_b%0d", f, b), ym, fm, (b == 7), 3'((b + 1) % 8), 1, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
